// File: rtl/decoder3x8_pkg.sv
// Shared constants and types for the 3-to-8 decoder.
// Holds widths, the one-hot bus type and a decode helper.
package decoder3x8_pkg;

    localparam int SEL_W = 3;
    localparam int OUT_W = 8;

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [OUT_W-1:0] onehot_t;

    // Binary code to one-hot line, bit index equals code.
    function automatic onehot_t onehot_of(input sel_t code);
        onehot_t v;
        v = '0;
        for (int i = 0; i < OUT_W; i++) begin
            if (sel_t'(i) == code) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/decoder3x8_core.sv
// Combinational 3-to-8 one-hot decode with enable.
// Output is logical polarity; a disabled decode is all zeros.
module decoder3x8_core
    import decoder3x8_pkg::*;
(
    input  logic [SEL_W-1:0] in,
    input  logic             en,
    output logic [OUT_W-1:0] onehot
);

    // Enable gates the decode so an unknown select never leaks out.
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot = onehot_of(in);
        end
    end

endmodule

// File: rtl/decoder3x8.sv
// 3-to-8 decoder top: optional output register, port polarity,
// valid flag and captured select code around the core.
module decoder3x8
    import decoder3x8_pkg::*;
#(
    parameter bit REGISTERED     = 1'b1,
    parameter bit OUT_ACTIVE_LOW = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SEL_W-1:0] in,
    input  logic             en,
    output logic [OUT_W-1:0] out,
    output logic             out_valid,
    output logic [SEL_W-1:0] code_q
);

    onehot_t dec;
    onehot_t res;

    decoder3x8_core u_core (
        .in     (in),
        .en     (en),
        .onehot (dec)
    );

    generate
        if (REGISTERED) begin : g_reg
            onehot_t res_q;
            logic    valid_q;
            sel_t    code_r;

            // Capture decode each edge; code only moves on enabled cycles.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    res_q   <= '0;
                    valid_q <= 1'b0;
                    code_r  <= '0;
                end else begin
                    res_q   <= dec;
                    valid_q <= en;
                    if (en) begin
                        code_r <= in;
                    end
                end
            end

            assign res       = res_q;
            assign out_valid = valid_q;
            assign code_q    = code_r;
        end else begin : g_comb
            logic unused;

            // Clock and reset have no role on the combinational path.
            assign unused    = clk ^ rst_n;
            assign res       = dec;
            assign out_valid = en;
            assign code_q    = in;
        end
    endgenerate

    // Polarity is applied only at the out port.
    always_comb begin
        out = res;
        if (OUT_ACTIVE_LOW) begin
            out = ~res;
        end
    end

endmodule

// File: tb/tb_decoder3x8.sv
// Directed bench for decoder3x8 covering registered,
// active-low and combinational builds side by side.
module tb_decoder3x8;

    logic       clk;
    logic       rst_n;
    logic [2:0] in;
    logic       en;

    logic [7:0] out_r, out_l, out_c;
    logic       vld_r, vld_l, vld_c;
    logic [2:0] code_r, code_l, code_c;

    int total = 0;
    int bad   = 0;

    decoder3x8 #(.REGISTERED(1'b1), .OUT_ACTIVE_LOW(1'b0)) u_reg (
        .clk(clk), .rst_n(rst_n), .in(in), .en(en),
        .out(out_r), .out_valid(vld_r), .code_q(code_r)
    );

    decoder3x8 #(.REGISTERED(1'b1), .OUT_ACTIVE_LOW(1'b1)) u_low (
        .clk(clk), .rst_n(rst_n), .in(in), .en(en),
        .out(out_l), .out_valid(vld_l), .code_q(code_l)
    );

    decoder3x8 #(.REGISTERED(1'b0), .OUT_ACTIVE_LOW(1'b0)) u_comb (
        .clk(clk), .rst_n(rst_n), .in(in), .en(en),
        .out(out_c), .out_valid(vld_c), .code_q(code_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_oh;

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        in    = 3'b101;
        #3;
        chk("rst_out", out_r, 8'h00);
        chk("rst_vld", {7'd0, vld_r}, 8'h00);
        chk("rst_code", {5'd0, code_r}, 8'h00);
        chk("rst_out_low", out_l, 8'hFF);
        chk("rst_comb_out", out_c, 8'h20);
        chk("rst_comb_vld", {7'd0, vld_c}, 8'h01);

        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b0;
        in    = 3'b000;
        step();
        chk("dis_out", out_r, 8'h00);
        chk("dis_vld", {7'd0, vld_r}, 8'h00);
        chk("dis_code", {5'd0, code_r}, 8'h00);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            en = 1'b1;
            in = 3'(i);
            exp_oh = 8'h01 << i;
            #1;
            chk("comb_out", out_c, exp_oh);
            chk("comb_code", {5'd0, code_c}, 8'(i));
            chk("pre_edge_out", out_r, (i == 0) ? 8'h00 : exp_oh >> 1);
            step();
            chk("sweep_out", out_r, exp_oh);
            chk("sweep_vld", {7'd0, vld_r}, 8'h01);
            chk("sweep_code", {5'd0, code_r}, 8'(i));
            chk("sweep_low", out_l, ~exp_oh);
        end

        @(negedge clk);
        in = 3'b011;
        step();
        chk("hold_out1", out_r, 8'h08);
        @(negedge clk);
        en = 1'b0;
        in = 3'b110;
        #1;
        chk("comb_dis", out_c, 8'h00);
        chk("comb_dis_vld", {7'd0, vld_c}, 8'h00);
        step();
        chk("hold_out0", out_r, 8'h00);
        chk("hold_vld", {7'd0, vld_r}, 8'h00);
        chk("hold_code", {5'd0, code_r}, 8'h03);
        chk("hold_low", out_l, 8'hFF);
        chk("low_code", {5'd0, code_l}, 8'h03);

        @(negedge clk);
        en = 1'b1;
        step();
        chk("low_sel6", out_l, 8'hBF);
        chk("low_vld", {7'd0, vld_l}, 8'h01);
        @(negedge clk);
        en = 1'b0;
        step();
        chk("low_dis", out_l, 8'hFF);

        @(negedge clk);
        en = 1'b1;
        in = 3'b111;
        #1;
        chk("comb_sel7", out_c, 8'h80);

        @(negedge clk);
        en = 1'b0;
        in = 3'bxxx;
        step();
        chk("x_dis_out", out_r, 8'h00);
        chk("x_dis_code", {5'd0, code_r}, 8'h07);

        @(negedge clk);
        en = 1'b1;
        in = 3'b010;
        step();
        chk("mid_out", out_r, 8'h04);
        @(negedge clk);
        in = 3'b001;
        rst_n = 1'b0;
        #1;
        chk("async_out", out_r, 8'h00);
        chk("async_vld", {7'd0, vld_r}, 8'h00);
        chk("async_code", {5'd0, code_r}, 8'h00);
        chk("async_low", out_l, 8'hFF);
        step();
        chk("rst_held", out_r, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        in = 3'b100;
        step();
        chk("post_rst_out", out_r, 8'h10);
        chk("post_rst_vld", {7'd0, vld_r}, 8'h01);
        chk("post_rst_code", {5'd0, code_r}, 8'h04);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decoder3x8.md
DECODER3X8 -- requirements
Module: decoder3x8

Interface
REQ-001 Parameter REGISTERED, default 1: 1 = outputs registered (1-cycle latency); 0 = purely combinational path, clk/rst_n unused.
REQ-002 Parameter OUT_ACTIVE_LOW, default 0: 1 = out bus inverted at the port (selected line 0, others 1).
REQ-003 clk  input  1  single clock, rising-edge active.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in  input  3  binary select code, in[2] MSB.
REQ-006 en  input  1  decode enable, active-high.
REQ-007 out  output  8  one-hot decoded result, bit index equals in.
REQ-008 out_valid  output  1  high when out reflects an enabled decode.
REQ-009 code_q  output  3  select code captured with the current out value.

Function
REQ-010 With en=1, logical result SHALL be out[i]=1 iff i==in, all other bits 0.
REQ-011 With en=0, logical result SHALL be 8'b0000_0000 regardless of in, including in containing X/Z.
REQ-012 Exactly one bit of out SHALL be set when out_valid=1; zero bits SHALL be set when out_valid=0 (logical polarity).
REQ-013 REGISTERED=1: out, out_valid, code_q SHALL update on each rising clk edge from in/en sampled at that edge; latency exactly 1 cycle, throughput 1 decode per cycle, no stall or backpressure.
REQ-014 REGISTERED=0: out SHALL follow in/en combinationally with zero cycle latency; out_valid=en; code_q=in.
REQ-015 out_valid SHALL equal en delayed by the same latency as out.
REQ-016 code_q SHALL hold the sampled in when en=1 and SHALL hold its previous value when en=0.
REQ-017 OUT_ACTIVE_LOW=1 SHALL invert only the out port; out_valid and code_q are unaffected.
REQ-018 Back-to-back changes of in on consecutive cycles SHALL each produce a distinct registered result; no cycle skipped.
REQ-019 en toggling 1->0 SHALL clear out on the next edge; 0->1 SHALL produce the decoded line on the next edge.
REQ-020 Codes 3'b000 and 3'b111 (boundary values) SHALL map to out[0] and out[7] respectively; no wrap or saturation logic exists.

Reset
REQ-021 rst_n low SHALL immediately, without a clock edge, force logical out=8'h00, out_valid=0, code_q=3'b000 (port out=8'hFF when OUT_ACTIVE_LOW=1).
REQ-022 Reset asserted mid-operation SHALL discard the in-flight decode; first valid result appears on the first rising edge after rst_n returns high with en=1.
REQ-023 Reset SHALL have no effect when REGISTERED=0 other than being ignored.

Structure
REQ-024 Shared package decoder3x8_pkg SHALL hold constants SEL_W=3 and OUT_W=8 and the one-hot typedef for the 8-bit bus.
REQ-025 One combinational sub-module decoder3x8_core (in, en -> logical one-hot) SHALL be instantiated; the top adds optional registering, polarity inversion, out_valid and code_q.
REQ-026 No latches; all registers SHALL use the asynchronous active-low reset of REQ-021.

Verification
REQ-027 Hold rst_n=0, en=1, in=3'b101 -> out=8'h00, out_valid=0 with no clock edge required.
REQ-028 en=0, in=3'b000, one edge -> out=8'b0000_0000, out_valid=0.
REQ-029 en=1, sweep in 0..7 on consecutive edges -> out one cycle later = 8'h01,02,04,08,10,20,40,80; out_valid=1; code_q tracks in.
REQ-030 en=1, in=3'b011 then en=0 -> out=8'h08 then 8'h00; code_q stays 3'b011.
REQ-031 OUT_ACTIVE_LOW=1, en=1, in=3'b110 -> out=8'b1011_1111; en=0 -> out=8'hFF.
REQ-032 REGISTERED=0, en=1, in=3'b111 -> out=8'h80 in the same timestep; assert rst_n low mid-sweep at REGISTERED=1 -> outputs clear asynchronously.
